// File: rtl/batalha_pkg.sv
// Shared definitions for the battleship board datapath.
// Holds board geometry, 2-bit cell codes, shot result codes, the shot
// resolver state encoding and the latched-shot record.
package batalha_pkg;

    localparam int BOARD_ROWS = 32;
    localparam int BOARD_COLS = 32;
    localparam int ROW_W      = 2 * BOARD_COLS;   // 64-bit row, 2 bits per column
    localparam int ADDR_W     = 5;                // row / column index width
    localparam int HIT_W      = 10;               // per-player hit counter width

    // Cell codes stored in board memory
    localparam logic [1:0] CELL_WATER = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_MISS  = 2'b10;
    localparam logic [1:0] CELL_HIT   = 2'b11;

    // Result codes reported to the game FSM
    localparam logic [1:0] RES_MISS   = 2'b00;
    localparam logic [1:0] RES_HIT    = 2'b01;
    localparam logic [1:0] RES_REPEAT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_EVAL,
        ST_WRITE,
        ST_DONE
    } shot_state_t;

    typedef struct packed {
        logic              player;
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
    } shot_t;

    // Marking a fresh cell: water becomes miss mark, ship becomes hit mark.
    // Bit 0 (ship) carries through, bit 1 flags "already shot".
    function automatic logic [1:0] mark_cell(input logic [1:0] old_cell);
        return {1'b1, old_cell[0]};
    endfunction

endpackage

// File: rtl/board_row_patch.sv
// Combinational row patcher.
// row      : 64-bit board row as read from memory
// col      : column whose 2-bit cell is replaced
// new_cell : replacement cell code
// row_out  : row with only that column replaced
// old_cell : cell code currently stored at that column
module board_row_patch
    import batalha_pkg::*;
(
    input  logic [ROW_W-1:0]  row,
    input  logic [ADDR_W-1:0] col,
    input  logic [1:0]        new_cell,
    output logic [ROW_W-1:0]  row_out,
    output logic [1:0]        old_cell
);

    logic [ADDR_W:0] bit_pos;   // column c lives at bits [2c+1:2c]

    assign bit_pos  = {col, 1'b0};
    assign old_cell = row[bit_pos +: 2];
    assign row_out  = (row & ~(ROW_W'(2'b11) << bit_pos)) | (ROW_W'(new_cell) << bit_pos);

endmodule

// File: rtl/shot_resolver.sv
// Resolves one shot against a player's board through the memory
// controller's collision port: read row, decode cell, write the marked
// row back, report miss/hit/repeat, and keep per-player hit counters.
// Ports:
//   clk, resetGeral            clock, async active-high reset
//   shot_valid/ready/player/row/col   shot handshake from game FSM
//   result_valid, result_code  one-cycle result pulse, code held
//   hits_p1, hits_p2, game_over      score outputs
//   clear_scores               counter clear (IDLE only)
//   readyColisor, jogadorColisor, colisor_addr, colisor_wrep1/2,
//   colisor_data, dataReadColisor    collision port to the controller
module shot_resolver
    import batalha_pkg::*;
#(
    parameter int READ_LAT   = 3,
    parameter int SHIP_CELLS = 17
) (
    input  logic              clk,
    input  logic              resetGeral,
    input  logic              shot_valid,
    input  logic              shot_player,
    input  logic [ADDR_W-1:0] shot_row,
    input  logic [ADDR_W-1:0] shot_col,
    output logic              shot_ready,
    output logic              result_valid,
    output logic [1:0]        result_code,
    output logic [HIT_W-1:0]  hits_p1,
    output logic [HIT_W-1:0]  hits_p2,
    output logic              game_over,
    input  logic              clear_scores,
    output logic              readyColisor,
    output logic              jogadorColisor,
    output logic [ADDR_W-1:0] colisor_addr,
    output logic              colisor_wrep1,
    output logic              colisor_wrep2,
    output logic [ROW_W-1:0]  colisor_data,
    input  logic [ROW_W-1:0]  dataReadColisor
);

    localparam int WAIT_W = $clog2(READ_LAT + 1);
    localparam logic [HIT_W-1:0] HIT_MAX  = '1;
    localparam logic [HIT_W-1:0] HIT_GOAL = HIT_W'(SHIP_CELLS);

    shot_state_t       state;
    shot_t             shot_q;
    logic [ROW_W-1:0]  row_q;
    logic [ROW_W-1:0]  row_patched;
    logic [1:0]        old_cell;
    logic [1:0]        new_cell;
    logic [1:0]        code_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              armed;      // holds shot_ready low for the first clock after reset
    logic              in_write;
    logic              accept;

    assign new_cell = mark_cell(old_cell);

    board_row_patch u_patch (
        .row      (row_q),
        .col      (shot_q.col),
        .new_cell (new_cell),
        .row_out  (row_patched),
        .old_cell (old_cell)
    );

    // Collision-port outputs are decoded from state so they drop the
    // instant reset asserts; an in-flight write is simply abandoned.
    assign shot_ready     = armed && (state == ST_IDLE);
    assign accept         = shot_valid && shot_ready;
    assign in_write       = (state == ST_WRITE);
    assign readyColisor   = (state == ST_REQ) || (state == ST_EVAL) || in_write;
    assign jogadorColisor = shot_q.player;
    assign colisor_addr   = shot_q.row;
    assign colisor_wrep1  = in_write && !shot_q.player;
    assign colisor_wrep2  = in_write &&  shot_q.player;
    assign colisor_data   = in_write ? row_patched : '0;
    assign game_over      = (hits_p1 == HIT_GOAL) || (hits_p2 == HIT_GOAL);

    always_ff @(posedge clk or posedge resetGeral) begin
        if (resetGeral) begin
            state        <= ST_IDLE;
            shot_q       <= '0;
            row_q        <= '0;
            code_q       <= RES_MISS;
            wait_cnt     <= '0;
            armed        <= 1'b0;
            result_valid <= 1'b0;
            result_code  <= RES_MISS;
            hits_p1      <= '0;
            hits_p2      <= '0;
        end else begin
            armed        <= 1'b1;
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_scores) begin
                        hits_p1 <= '0;
                        hits_p2 <= '0;
                    end
                    if (accept) begin
                        shot_q.player <= shot_player;
                        shot_q.row    <= shot_row;
                        shot_q.col    <= shot_col;
                        wait_cnt      <= WAIT_W'(1);
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Read data is valid on the READ_LAT-th request cycle
                    if (wait_cnt == WAIT_W'(READ_LAT)) begin
                        row_q <= dataReadColisor;
                        state <= ST_EVAL;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_EVAL: begin
                    if (old_cell[1]) begin
                        // Already marked: report repeat, leave memory alone
                        code_q       <= RES_REPEAT;
                        result_code  <= RES_REPEAT;
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        code_q <= old_cell[0] ? RES_HIT : RES_MISS;
                        state  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    result_code  <= code_q;
                    result_valid <= 1'b1;
                    state        <= ST_DONE;
                end
                ST_DONE: begin
                    if (code_q == RES_HIT) begin
                        if (shot_q.player) begin
                            if (hits_p2 != HIT_MAX) hits_p2 <= hits_p2 + HIT_W'(1);
                        end else begin
                            if (hits_p1 != HIT_MAX) hits_p1 <= hits_p1 + HIT_W'(1);
                        end
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shot_resolver.sv
module tb_shot_resolver;
    import batalha_pkg::*;

    localparam int READ_LAT   = 3;
    localparam int SHIP_CELLS = 17;

    logic        clk = 1'b0;
    logic        resetGeral = 1'b1;
    logic        shot_valid = 1'b0;
    logic        shot_player = 1'b0;
    logic [4:0]  shot_row = '0;
    logic [4:0]  shot_col = '0;
    logic        clear_scores = 1'b0;
    logic        shot_ready, result_valid, game_over;
    logic [1:0]  result_code;
    logic [9:0]  hits_p1, hits_p2;
    logic        readyColisor, jogadorColisor, colisor_wrep1, colisor_wrep2;
    logic [4:0]  colisor_addr;
    logic [63:0] colisor_data, dataReadColisor;

    always #5 clk = ~clk;

    shot_resolver #(.READ_LAT(READ_LAT), .SHIP_CELLS(SHIP_CELLS)) dut (
        .clk(clk), .resetGeral(resetGeral),
        .shot_valid(shot_valid), .shot_player(shot_player), .shot_row(shot_row), .shot_col(shot_col),
        .shot_ready(shot_ready), .result_valid(result_valid), .result_code(result_code),
        .hits_p1(hits_p1), .hits_p2(hits_p2), .game_over(game_over), .clear_scores(clear_scores),
        .readyColisor(readyColisor), .jogadorColisor(jogadorColisor), .colisor_addr(colisor_addr),
        .colisor_wrep1(colisor_wrep1), .colisor_wrep2(colisor_wrep2),
        .colisor_data(colisor_data), .dataReadColisor(dataReadColisor)
    );

    // ---------------- memory controller model ----------------
    logic [63:0] mem [2][32];
    int          rc_cnt;
    logic        ld_en = 1'b0, ld_p = 1'b0;
    logic [4:0]  ld_r = '0;
    logic [63:0] ld_data = '0;

    always @(posedge clk or posedge resetGeral)
        if (resetGeral) rc_cnt <= 0;
        else            rc_cnt <= readyColisor ? rc_cnt + 1 : 0;

    always @(posedge clk) begin
        if (ld_en)         mem[ld_p][ld_r]      <= ld_data;
        if (colisor_wrep1) mem[0][colisor_addr] <= colisor_data;
        if (colisor_wrep2) mem[1][colisor_addr] <= colisor_data;
    end

    // Read data is only meaningful from the READ_LAT-th request cycle on
    always_comb begin
        dataReadColisor = 64'hA5A5_5A5A_F00D_BEEF;
        if (readyColisor && rc_cnt >= READ_LAT - 1) dataReadColisor = mem[jogadorColisor][colisor_addr];
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic       p;
        logic [4:0] r, c;
        logic [1:0] code, newc;
        int         done_cyc;
    } res_t;
    typedef struct {
        logic        p;
        logic [4:0]  r;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    logic [1:0] refc [2][32][32];
    int         exp_h [2];
    res_t       rq[$];
    wr_t        wq[$];
    int         total = 0, bad = 0, cyc = 0, nres = 0, last_done = -100, hold_acc = 0;
    logic       chk_next = 1'b0, hold_mode = 1'b0;
    res_t       e_acc, e_done;
    wr_t        w_acc, w_mon;
    logic [1:0] old_c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    function automatic logic go_model();
        return (exp_h[0] == SHIP_CELLS) || (exp_h[1] == SHIP_CELLS);
    endfunction

    always @(negedge clk or posedge resetGeral) begin
        if (resetGeral) begin
            rq.delete();
            wq.delete();
            exp_h[0] = 0;
            exp_h[1] = 0;
            chk_next  = 1'b0;
            last_done = -100;
        end else begin
            if (!hold_mode) hold_acc = 0;
            if (chk_next) begin
                chk("hits_p1", 64'(hits_p1), 64'(exp_h[0]));
                chk("hits_p2", 64'(hits_p2), 64'(exp_h[1]));
                chk("game_over", 64'(game_over), 64'(go_model()));
                chk_next = 1'b0;
            end
            if (ld_en)
                for (int c = 0; c < 32; c++) refc[ld_p][ld_r][c] = ld_data[2*c +: 2];
            if (result_valid) begin
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_result actual=%0h required=none", result_code);
                end else begin
                    e_done = rq.pop_front();
                    chk("result_code", 64'(result_code), 64'(e_done.code));
                    chk("done_cycle", 64'(cyc), 64'(e_done.done_cyc));
                    chk("game_over_at_done", 64'(game_over), 64'(go_model()));
                    if (e_done.code != RES_REPEAT) refc[e_done.p][e_done.r][e_done.c] = e_done.newc;
                    if (e_done.code == RES_HIT && exp_h[e_done.p] < 1023) exp_h[e_done.p]++;
                    chk_next  = 1'b1;
                    last_done = cyc;
                    nres++;
                end
            end
            if (colisor_wrep1 || colisor_wrep2) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write actual=%0h required=none", colisor_data);
                end else begin
                    w_mon = wq.pop_front();
                    chk("wr_single", 64'(colisor_wrep1 & colisor_wrep2), 64'd0);
                    chk("wr_board", 64'(colisor_wrep2), 64'(w_mon.p));
                    chk("wr_addr", 64'(colisor_addr), 64'(w_mon.r));
                    chk("wr_data", colisor_data, w_mon.data);
                    chk("wr_cycle", 64'(cyc), 64'(w_mon.cyc));
                end
            end
            if (shot_ready && clear_scores) begin
                exp_h[0] = 0;
                exp_h[1] = 0;
            end
            if (shot_valid && shot_ready) begin
                if (hold_mode) begin
                    hold_acc++;
                    if (hold_acc > 1) chk("hold_reaccept", 64'(cyc), 64'(last_done + 1));
                end
                old_c    = refc[shot_player][shot_row][shot_col];
                e_acc.p  = shot_player;
                e_acc.r  = shot_row;
                e_acc.c  = shot_col;
                case (old_c)
                    CELL_WATER: begin e_acc.code = RES_MISS;   e_acc.newc = CELL_MISS; end
                    CELL_SHIP:  begin e_acc.code = RES_HIT;    e_acc.newc = CELL_HIT;  end
                    default:    begin e_acc.code = RES_REPEAT; e_acc.newc = old_c;     end
                endcase
                // accept edge is the next posedge; the cycle after it is cyc+1
                if (e_acc.code == RES_REPEAT) begin
                    e_acc.done_cyc = cyc + 1 + READ_LAT + 1;
                end else begin
                    e_acc.done_cyc = cyc + 1 + READ_LAT + 2;
                    w_acc.p   = shot_player;
                    w_acc.r   = shot_row;
                    w_acc.cyc = cyc + 1 + READ_LAT + 1;
                    for (int c = 0; c < 32; c++)
                        w_acc.data[2*c +: 2] = (c == int'(shot_col)) ? e_acc.newc : refc[shot_player][shot_row][c];
                    wq.push_back(w_acc);
                end
                rq.push_back(e_acc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_row(input logic p, input logic [4:0] r, input logic [63:0] d);
        ld_en = 1'b1; ld_p = p; ld_r = r; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic fire(input logic p, input logic [4:0] r, input logic [4:0] c, input logic clr);
        int n;
        shot_valid = 1'b1; shot_player = p; shot_row = r; shot_col = c; clear_scores = clr;
        n = 0;
        @(negedge clk);
        while (!shot_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!shot_ready) fail("accept_wait");
        @(posedge clk);
        #1;
        shot_valid = 1'b0;
        clear_scores = 1'b0;
    endtask

    task automatic wait_results(input int target);
        int n;
        n = 0;
        while (nres < target && n < 60) begin
            tick();
            n++;
        end
        if (nres < target) fail("result_wait");
    endtask

    task automatic shot(input logic p, input logic [4:0] r, input logic [4:0] c, input logic clr);
        int base;
        base = nres;
        fire(p, r, c, clr);
        wait_results(base + 1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base, n;
        logic [63:0] d;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_shot_ready", 64'(shot_ready), 64'd0);
        chk("rst_ready_colisor", 64'(readyColisor), 64'd0);
        chk("rst_result_valid", 64'(result_valid), 64'd0);
        chk("rst_hits", 64'({hits_p1, hits_p2}), 64'd0);
        chk("rst_game_over", 64'(game_over), 64'd0);
        resetGeral = 1'b0;
        @(negedge clk);
        chk("ready_before_first_clk", 64'(shot_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_first_clk", 64'(shot_ready), 64'd1);
        tick();

        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 32; r++) load_row(p[0], r[4:0], 64'd0);
        load_row(1'b0, 5'd3, 64'h0000_0000_0000_0040);

        // hit on a ship cell
        shot(1'b0, 5'd3, 5'd3, 1'b0);
        chk("hit_row_written", mem[0][3], 64'h0000_0000_0000_00C0);
        chk("hit_count", 64'(hits_p1), 64'd1);

        // miss on last column of board 1
        shot(1'b1, 5'd0, 5'd31, 1'b0);
        chk("miss_row_written", mem[1][0], 64'h8000_0000_0000_0000);
        chk("miss_no_count", 64'({hits_p1, hits_p2}), 64'({10'd1, 10'd0}));

        // repeat: no write, counter unchanged
        shot(1'b0, 5'd3, 5'd3, 1'b0);
        chk("repeat_row_kept", mem[0][3], 64'h0000_0000_0000_00C0);
        chk("repeat_count", 64'(hits_p1), 64'd1);

        // shot_valid held through transactions
        base = nres;
        hold_mode = 1'b1;
        shot_valid = 1'b1; shot_player = 1'b1; shot_row = 5'd5; shot_col = 5'd7;
        n = 0;
        while (nres < base + 2 && n < 80) begin
            tick();
            n++;
        end
        if (nres < base + 2) fail("hold_wait");
        shot_valid = 1'b0;
        repeat (10) tick();
        hold_mode = 1'b0;
        chk("hold_result_count", 64'(nres), 64'(base + 2));

        // reset during WRITE abandons the write
        fire(1'b0, 5'd20, 5'd4, 1'b0);
        n = 0;
        @(negedge clk);
        while (!colisor_wrep1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!colisor_wrep1) fail("write_wait");
        #2;
        resetGeral = 1'b1;
        #1;
        chk("rstw_wren", 64'({colisor_wrep1, colisor_wrep2}), 64'd0);
        chk("rstw_ready_colisor", 64'(readyColisor), 64'd0);
        chk("rstw_data", colisor_data, 64'd0);
        chk("rstw_addr_player", 64'({colisor_addr, jogadorColisor}), 64'd0);
        chk("rstw_result", 64'({result_valid, result_code}), 64'd0);
        chk("rstw_hits", 64'({hits_p1, hits_p2}), 64'd0);
        chk("rstw_shot_ready", 64'(shot_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        resetGeral = 1'b0;
        @(negedge clk);
        chk("rstw_ready_release", 64'(shot_ready), 64'd0);
        @(negedge clk);
        chk("rstw_ready_next", 64'(shot_ready), 64'd1);
        chk("rstw_row_unchanged", mem[0][20], 64'd0);
        tick();

        // 17 ship cells -> game over, then clear
        d = '0;
        for (int c = 0; c < SHIP_CELLS; c++) d[2*c] = 1'b1;
        load_row(1'b0, 5'd8, d);
        for (int c = 0; c < SHIP_CELLS; c++) shot(1'b0, 5'd8, c[4:0], 1'b0);
        chk("go_hits", 64'(hits_p1), 64'(SHIP_CELLS));
        chk("go_flag", 64'(game_over), 64'd1);
        clear_scores = 1'b1;
        tick();
        clear_scores = 1'b0;
        @(negedge clk);
        chk("clear_hits", 64'(hits_p1), 64'd0);
        chk("clear_game_over", 64'(game_over), 64'd0);
        tick();

        // randomized boards and shots
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 32; r++) begin
                for (int c = 0; c < 32; c++) d[2*c +: 2] = 2'($urandom_range(0, 3));
                load_row(p[0], r[4:0], d);
            end
        for (int i = 0; i < 60; i++) begin
            shot(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 9) == 0));
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (4) tick();
        chk("results_drained", 64'(rq.size()), 64'd0);
        chk("writes_drained", 64'(wq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shot_resolver.md
# shot_resolver

Requester-side client of the board memory controller: resolves one player shot against the target player's 32×32 board by issuing a read-modify-write through the controller's collision port (`readyColisor`/`jogadorColisor`/`colisor_*`). Reads the addressed row, decodes the 2-bit cell, writes the updated row back and reports miss/hit/repeat. Keeps per-player hit counters and flags game over. Sits between the game-flow FSM, which fires shots, and the memory controller.

## Interface
- `READ_LAT`, 3: cycles from `readyColisor`+`colisor_addr` first asserted to valid `dataReadColisor`. Covers controller state switch plus synchronous RAM read.
- `SHIP_CELLS`, 17: ship cells per board; reaching this hit count ends the game.
- `clk` in 1: single clock, rising edge.
- `resetGeral` in 1: asynchronous, active-high reset.
- `shot_valid` in 1: shot request from game FSM.
- `shot_player` in 1: target board; 0 = player-one memory, 1 = player-two memory.
- `shot_row` in 5: board row, used as memory address.
- `shot_col` in 5: board column.
- `shot_ready` out 1: high only in IDLE; a shot is accepted when `shot_valid & shot_ready`.
- `result_valid` out 1: one-cycle pulse in DONE.
- `result_code` out 2: 00 miss, 01 hit, 10 repeat; held until the next DONE.
- `hits_p1`, `hits_p2` out 10 each: hits scored against board 0 and board 1.
- `game_over` out 1: high while either counter equals `SHIP_CELLS`.
- `clear_scores` in 1: synchronous clear of counters; honored only in IDLE.
- `readyColisor` out 1: collision-port request to controller.
- `jogadorColisor` out 1: equals latched `shot_player`.
- `colisor_addr` out 5: latched `shot_row`.
- `colisor_wrep1`, `colisor_wrep2` out 1 each: write enable to board 0 / board 1.
- `colisor_data` out 64: updated row.
- `dataReadColisor` in 64: row read back via controller.

## Operation
- Row layout: column c occupies bits [2c+1:2c]. Cell codes: 00 water, 01 ship, 10 miss mark, 11 hit mark.
- States:
  - IDLE: `shot_ready`=1. On accept, latch player/row/col, then go to REQ.
  - REQ: `readyColisor`=1 and address driven; wait counter runs 1..`READ_LAT`. At the final count, capture `dataReadColisor` into the row register, then go to EVAL.
  - EVAL: extract the cell.
    - 00: new cell 10, code miss, go to WRITE.
    - 01: new cell 11, code hit, go to WRITE.
    - 10 or 11: code repeat, go directly to DONE with no write.
  - WRITE: `readyColisor` held; the `colisor_wrep*` of the target board is 1, the other is 0. `colisor_data` = captured row with only column c replaced. Then go to DONE.
  - DONE: `readyColisor`=0, `result_valid`=1. On hit, increment the target board's counter. Return to IDLE.
- Counters saturate at 1023. `game_over` is combinational from the counters.
- The game FSM asserts `shot_valid` only when the validator port is idle; the controller gives the validator priority, and the resolver does not arbitrate.
- `shot_valid` outside IDLE is ignored; no queuing.
- Simultaneous `clear_scores` and accept in IDLE: counters clear and the shot is accepted.
- Reset: all outputs 0, state IDLE, counters 0, `result_code` 00. `shot_ready` rises on the first clock after reset release. A write in flight is abandoned because wren drops asynchronously; the row stays unmodified.

## Timing
- Accept at edge t0.
- REQ occupies cycles t0+1..t0+`READ_LAT`; EVAL is t0+`READ_LAT`+1.
- Hit/miss: WRITE at t0+`READ_LAT`+2, DONE at t0+`READ_LAT`+3.
- Repeat: DONE at t0+`READ_LAT`+2.
- Counter update is visible the cycle after DONE. Next accept is possible the cycle after DONE.
- `readyColisor` is continuous from REQ through WRITE, so the controller stays in the collision state for the write.
- All outputs are registered except `game_over`, `shot_ready` and the collision-port outputs, which are decoded from state plus latched fields.

## Structure
- Shared package `batalha_pkg` holds:
  - cell codes (`CELL_WATER`, `CELL_SHIP`, `CELL_MISS`, `CELL_HIT`);
  - result codes;
  - state encoding;
  - board geometry constants (32 rows, 32 columns, 64-bit row).
- Sub-module `board_row_patch` (combinational): inputs row, column and new cell; outputs the patched row and the old cell.
- The top level holds the FSM, wait counter and hit counters.

## Test plan
- Board 0, row 3 = 64'h0000_0000_0000_0040 (column 3 = ship), shot (0,3,3):
  - `result_code`=01 at t0+6 with `READ_LAT`=3;
  - `colisor_wrep1` pulse with data 64'h…00C0;
  - `hits_p1`=1.
- Board 1, row 0 all water, shot (1,0,31):
  - miss;
  - `colisor_wrep2` with data 64'h8000_0000_0000_0000;
  - counters unchanged.
- Repeat the first shot: code 10 at t0+5, no wren pulse, `hits_p1` still 1.
- Preload 17 ship cells and fire all 17: `game_over` rises the cycle after the 17th DONE. Then `clear_scores` returns `hits_p1` to 0 and `game_over` to 0.
- Assert `resetGeral` during WRITE: all outputs drop immediately, memory row unchanged, `shot_ready`=1 one cycle after release.
- Hold `shot_valid` through a whole transaction: exactly one shot resolved per IDLE visit, with a new accept on the cycle after DONE.
